// File: rtl/result_demux_pkg.sv
// Shared constants for the result demultiplexer: channel count, widths, select codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package result_demux_pkg;

  localparam int unsigned RD_NCH    = 5;
  localparam int unsigned RD_SEL_W  = 4;
  localparam int unsigned RD_WIDTH  = 32;
  localparam int unsigned RD_DROP_W = 8;

  // Select encodings that address a real channel; every other code is dropped.
  typedef enum logic [RD_SEL_W-1:0] {
    SEL_CH0 = 4'd0,
    SEL_CH1 = 4'd1,
    SEL_CH2 = 4'd2,
    SEL_CH3 = 4'd3,
    SEL_CH4 = 4'd4
  } sel_e;

  // True when the select code addresses one of the nch implemented channels.
  function automatic logic sel_in_range(input logic [RD_SEL_W-1:0] sel,
                                        input int unsigned nch);
    return (32'(sel) < nch);
  endfunction

endpackage

// File: rtl/result_slot.sv
// One-entry holding register (valid + data) for a single output channel.
// Latency: load visible one edge later; drain clears valid on the same edge.
// Backpressure: load and drain may coincide (full-rate pass-through); data only changes on load.
module result_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Load wins over drain so a simultaneous load/drain keeps the slot full with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/result_demux.sv
// Routes one input word to one of NCH single-entry output channels by in_sel; bad selects are dropped and counted.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready stalls only while in_sel targets a full, non-draining channel; bad selects are always accepted.
module result_demux
  import result_demux_pkg::*;
#(
  parameter int unsigned WIDTH = RD_WIDTH,
  parameter int unsigned NCH   = RD_NCH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RD_SEL_W-1:0]  in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [WIDTH-1:0]     out_data0,
  output logic [WIDTH-1:0]     out_data1,
  output logic [WIDTH-1:0]     out_data2,
  output logic [WIDTH-1:0]     out_data3,
  output logic [WIDTH-1:0]     out_data4,
  output logic                 bad_sel,
  output logic [RD_DROP_W-1:0] drop_cnt
);

  logic                 w_sel_ok;
  logic                 w_in_ready;
  logic                 w_xfer_in;
  logic                 w_drop;
  logic [NCH-1:0]       w_load;
  logic [WIDTH-1:0]     w_data [RD_NCH];
  logic                 r_bad_sel;
  logic [RD_DROP_W-1:0] r_drop_cnt;

  assign w_sel_ok = sel_in_range(in_sel, NCH);

  // Ready reflects only the addressed channel; out-of-range selects are always sunk.
  always_comb begin
    w_in_ready = 1'b1;
    for (int k = 0; k < int'(NCH); k++) begin
      if (in_sel == k[RD_SEL_W-1:0]) begin
        w_in_ready = !out_valid[k] || out_ready[k];
      end
    end
  end

  assign w_xfer_in = in_valid && w_in_ready;
  assign w_drop    = w_xfer_in && !w_sel_ok;
  assign in_ready  = w_in_ready;

  // One-hot load decode of the accepted word onto its destination slot.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      w_load[k] = w_xfer_in && (in_sel == k[RD_SEL_W-1:0]);
    end
  end

  for (genvar k = 0; k < int'(RD_NCH); k++) begin : g_slot
    if (k < int'(NCH)) begin : g_used
      result_slot #(.WIDTH(WIDTH)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load[k]),
        .i_data  (in_data),
        .i_ready (out_ready[k]),
        .o_valid (out_valid[k]),
        .o_data  (w_data[k])
      );
    end else begin : g_unused
      assign w_data[k] = '0;
    end
  end

  assign out_data0 = w_data[0];
  assign out_data1 = w_data[1];
  assign out_data2 = w_data[2];
  assign out_data3 = w_data[3];
  assign out_data4 = w_data[4];

  // Sticky bad-select flag and saturating drop counter for dropped words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad_sel  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_bad_sel <= 1'b1;
      if (r_drop_cnt != {RD_DROP_W{1'b1}}) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign bad_sel  = r_bad_sel;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_result_demux.sv
module tb_result_demux;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel;
  logic [31:0] in_data;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3, out_data4;
  logic        bad_sel;
  logic [7:0]  drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  result_demux dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_data4 (out_data4),
    .bad_sel   (bad_sel),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] od(input int k);
    case (k)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      3: return out_data3;
      default: return out_data4;
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 4'd0;
    in_data   = 32'd0;
    out_ready = 5'b00000;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data0", 64'(out_data0), 64'h0);
    chk("rst_bad_sel",   64'(bad_sel),   64'h0);
    chk("rst_drop_cnt",  64'(drop_cnt),  64'h0);
    chk("rst_in_ready",  64'(in_ready),  64'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single word to channel 2, nothing draining.
    in_sel = 4'd2; in_data = 32'h4; in_valid = 1'b1;
    #1 chk("c2_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("c2_out_valid", 64'(out_valid), 64'b00100);
    chk("c2_out_data2", 64'(out_data2), 64'h4);
    chk("c2_out_data0", 64'(out_data0), 64'h0);
    chk("c2_out_data4", 64'(out_data4), 64'h0);
    chk("c2_bad_sel",   64'(bad_sel),   64'h0);
    chk("c2_drop_cnt",  64'(drop_cnt),  64'h0);

    // Head-of-line stall on full channel 2, then pass-through replacement.
    in_sel = 4'd2; in_data = 32'h55; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hol_in_ready", 64'(in_ready), 64'h0);
      tick();
      chk("hol_data2_held", 64'(out_data2), 64'h4);
      chk("hol_valid_held", 64'(out_valid), 64'b00100);
    end
    in_sel = 4'd3;
    #1 chk("other_ch_ready", 64'(in_ready), 64'h1);
    in_sel = 4'd2;
    out_ready = 5'b00100;
    #1 chk("drain_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0; out_ready = 5'b00000;
    #1;
    chk("pt_out_valid", 64'(out_valid), 64'b00100);
    chk("pt_out_data2", 64'(out_data2), 64'h55);
    out_ready = 5'b11111;
    tick();
    chk("drain_valid",   64'(out_valid), 64'h0);
    chk("drain_data_kp", 64'(out_data2), 64'h55);

    // Ignored input when in_valid is low.
    in_sel = 4'd1; in_data = 32'h99;
    tick();
    chk("novld_valid", 64'(out_valid), 64'h0);
    chk("novld_data1", 64'(out_data1), 64'h0);

    // Full-rate stream across all channels with everything ready.
    for (int s = 0; s < 5; s++) begin
      in_sel = 4'(s); in_data = 32'(1) << s; in_valid = 1'b1;
      #1 chk("str_in_ready", 64'(in_ready), 64'h1);
      tick();
      chk("str_out_valid", 64'(out_valid), 64'(5'b00001 << s));
      chk("str_out_data",  64'(od(s)),     64'(32'(1) << s));
    end
    in_valid = 1'b0;
    tick();
    chk("str_end_valid", 64'(out_valid), 64'h0);

    // Bad select: dropped, flagged, counted, saturating.
    out_ready = 5'b00000;
    in_sel = 4'd7; in_data = 32'hDEADBEEF; in_valid = 1'b1;
    #1 chk("bad_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bad_out_valid", 64'(out_valid), 64'h0);
    chk("bad_flag",      64'(bad_sel),   64'h1);
    chk("bad_cnt1",      64'(drop_cnt),  64'h1);
    chk("bad_data4",     64'(out_data4), 64'h10);
    in_sel = 4'd15; in_data = 32'h12345678; in_valid = 1'b1;
    for (int i = 0; i < 253; i++) tick();
    chk("bad_cnt254", 64'(drop_cnt), 64'd254);
    tick();
    chk("bad_cnt255", 64'(drop_cnt), 64'd255);
    for (int i = 0; i < 46; i++) tick();
    in_valid = 1'b0;
    chk("bad_cnt_sat",   64'(drop_cnt),  64'd255);
    chk("bad_sticky",    64'(bad_sel),   64'h1);
    chk("bad_no_change", 64'(out_valid), 64'h0);

    // Fill channels 0 and 4, then reset asynchronously between edges.
    in_sel = 4'd0; in_data = 32'hA0; in_valid = 1'b1;
    tick();
    in_sel = 4'd4; in_data = 32'hB4;
    tick();
    in_valid = 1'b0;
    chk("fill_valid", 64'(out_valid), 64'b10001);
    chk("fill_data4", 64'(out_data4), 64'hB4);
    #2;
    rst_n = 1'b0;
    in_sel = 4'd1; in_data = 32'h11; in_valid = 1'b1;
    #1;
    chk("arst_valid",  64'(out_valid), 64'h0);
    chk("arst_data0",  64'(out_data0), 64'h0);
    chk("arst_data4",  64'(out_data4), 64'h0);
    chk("arst_cnt",    64'(drop_cnt),  64'h0);
    chk("arst_bad",    64'(bad_sel),   64'h0);
    chk("arst_ready",  64'(in_ready),  64'h1);
    tick();
    chk("arst_lost", 64'(out_valid), 64'h0);
    rst_n = 1'b1;
    in_sel = 4'd3; in_data = 32'h33;
    tick();
    in_valid = 1'b0;
    chk("post_valid", 64'(out_valid), 64'b01000);
    chk("post_data3", 64'(out_data3), 64'h33);
    chk("post_data1", 64'(out_data1), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/result_demux.md
RESULT_DEMUX -- requirements
Module: result_demux

Interface
REQ-001 Parameter WIDTH, default 32, data width of every channel.
REQ-002 Parameter NCH, default 5, number of output channels; the select field is 4 bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_sel  input  4  destination channel index.
REQ-008 in_data  input  WIDTH  word to route.
REQ-009 out_valid  output  NCH  per-channel word held.
REQ-010 out_ready  input  NCH  per-channel downstream accept.
REQ-011 out_data0..out_data4  output  WIDTH each  per-channel held word.
REQ-012 bad_sel  output  1  sticky flag: a word with in_sel >= NCH was accepted.
REQ-013 drop_cnt  output  8  count of words dropped for bad select.

Function
REQ-014 The transfer rule SHALL be: transfer in = in_valid & in_ready; transfer out k = out_valid[k] & out_ready[k].
REQ-015 Each channel SHALL have a one-entry holding register (data + valid bit).
REQ-016 in_ready SHALL be combinational: 1 if in_sel >= NCH, otherwise (!out_valid[in_sel] | out_ready[in_sel]).
REQ-017 On transfer in with in_sel = k < NCH, the next edge SHALL load out_data_k <= in_data and set out_valid[k]; latency is exactly 1 cycle.
REQ-018 On transfer out k with no load to k, the edge SHALL clear out_valid[k]; with a simultaneous load to k, out_valid[k] SHALL stay 1 and the data SHALL be replaced (full-rate pass-through).
REQ-019 out_data_k SHALL hold its value while out_valid[k]=1 and out_ready[k]=0; it SHALL NOT change when out_valid[k]=0 either.
REQ-020 A full channel SHALL NOT block traffic to other channels, except that the single input port stalls while its current in_sel targets a full, non-draining channel (head-of-line).
REQ-021 A transfer in with in_sel >= NCH SHALL be dropped: no channel changes, bad_sel is set, and drop_cnt increments.
REQ-022 drop_cnt SHALL saturate at 255 and not wrap.
REQ-023 bad_sel SHALL stay set until reset.
REQ-024 Channels draining independently in the same cycle SHALL all drain.
REQ-025 in_data and in_sel SHALL be ignored when in_valid = 0.

Reset
REQ-026 rst_n low SHALL immediately force out_valid = 0, all out_data_k = 0, bad_sel = 0, and drop_cnt = 0, regardless of clk.
REQ-027 A reset asserted mid-transfer SHALL discard all held words; no partial state survives.
REQ-028 in_ready follows REQ-016 during reset (channels empty); words presented during reset are lost.
REQ-029 After rst_n rises, the first edge SHALL accept normally.

Structure
REQ-030 The channel count (5), select width (4), data width (32), and drop counter width (8) SHALL live in the shared ALU constants package, alongside the select encodings used by the mux.
REQ-031 A single sub-module, result_slot (one-entry valid/data holding register with load/drain), SHALL be instantiated NCH times.
REQ-032 The select decode and saturating counter SHALL be inline in result_demux.

Verification
REQ-033 After reset, drive in_sel=2, in_data=0x00000004, in_valid=1 for one cycle, with out_ready=0 -> next cycle out_valid=5'b00100, out_data2=4, and all other outputs 0.
REQ-034 With channel 2 full and out_ready[2]=0, present in_sel=2 -> in_ready=0 for 3 cycles, and out_data2 is unchanged; then raise out_ready[2] -> in_ready=1, and the new word replaces the old one with out_valid[2] held at 1.
REQ-035 With out_ready=5'b11111, stream sel 0,1,2,3,4 with data 2**sel on consecutive cycles -> each out_valid[k] pulses once, one cycle after its input, and in_ready stays 1 throughout.
REQ-036 Present in_sel=7, data=0xDEADBEEF -> in_ready=1, no out_valid change, bad_sel=1, drop_cnt=1; send 300 bad words -> drop_cnt=255.
REQ-037 Fill channels 0 and 4, then assert rst_n=0 between clock edges -> out_valid=0, out_data0 and out_data4 = 0, and drop_cnt=0 before the next edge.
